// File: rtl/emcu_flash_ahb_slave.sv
// emcu_flash_ahb_slave: AHB-Lite read-only slave in front of a FLASH256K-style macro.
// Optional one-word sequential prefetch buffer, enabled by defining EMCU_FLASH_PREFETCH_EN.
module emcu_flash_ahb_slave #(
  parameter int ADDR_W   = 13,
  parameter int READ_LAT = 1,
  parameter int WIN_W    = 18
) (
  input  logic              clk,
  input  logic              rst_i,
  input  logic              hsel,
  input  logic [31:0]       haddr,
  input  logic [1:0]        htrans,
  input  logic              hwrite,
  input  logic [2:0]        hsize,
  input  logic              hreadymux,
  output logic              hreadyout,
  output logic              hresp,
  output logic [31:0]       hrdata,
  output logic [ADDR_W-7:0] flash_xadr,
  output logic [5:0]        flash_yadr,
  output logic              flash_se,
  input  logic [31:0]       flash_dout
);

  typedef enum logic [2:0] {
    S_IDLE, S_SETUP, S_WAIT, S_DATA, S_ERR1, S_ERR2
  } state_t;

  localparam logic [ADDR_W-1:0] A_TOP  = '1;
  localparam logic [2:0]        LAT_M1 = 3'(READ_LAT - 1);

  state_t            state, state_nx;
  logic [2:0]        cnt;
  logic [ADDR_W-1:0] fa, fa_nx, req_a;
  logic              fa_ld, rd_ld;
  logic [31:0]       rd_nx;
  logic              acc, bad, oor, fin;
  logic              bg, pend, pend_err, pf_hit;
  logic [ADDR_W-1:0] pend_a, r_a;
  logic [31:0]       pf_data;
  logic              bg_go, pend_set, pf_fill;
  logic              r_go, r_bad, busy_ok;
  logic              unused_bus;

  // hreadyout gates acceptance so a stalled slave never takes a new phase
  assign acc   = hsel & htrans[1] & hreadymux & hreadyout;
  assign req_a = haddr[ADDR_W+1:2];
  assign bad   = hwrite | (hsize > 3'd2) | oor;
  assign fin   = (state == S_WAIT) && (cnt == '0);
  assign flash_xadr = fa[ADDR_W-1:6];
  assign flash_yadr = fa[5:0];
  assign unused_bus = ^{haddr[31:WIN_W], haddr[1:0], htrans[0]};

  generate
    if (WIN_W > ADDR_W + 2) begin : g_win
      assign oor = |haddr[WIN_W-1:ADDR_W+2];
    end else begin : g_nowin
      assign oor = 1'b0;
    end
  endgenerate

  // request seen at the end of a background read: held one or live one
  assign r_go    = pend | acc;
  assign r_bad   = pend ? pend_err : bad;
  assign r_a     = pend ? pend_a : req_a;
  assign busy_ok = bg & ~pend;

`ifdef EMCU_FLASH_PREFETCH_EN
  localparam bit PF_EN = 1'b1;
  logic              pf_valid;
  logic [ADDR_W-1:0] pf_addr;

  assign pf_hit = pf_valid && (req_a == pf_addr);

  // prefetch buffer and held request while a background read runs
  always_ff @(posedge clk or negedge rst_i) begin
    if (!rst_i) begin
      bg       <= 1'b0;
      pend     <= 1'b0;
      pend_err <= 1'b0;
      pend_a   <= '0;
      pf_valid <= 1'b0;
      pf_addr  <= '0;
      pf_data  <= '0;
    end else begin
      if (bg_go) bg <= 1'b1;
      else if (fin) bg <= 1'b0;
      if (pend_set) begin
        pend     <= 1'b1;
        pend_err <= bad;
        pend_a   <= req_a;
      end else if (fin) begin
        pend <= 1'b0;
      end
      if (pf_fill) begin
        pf_valid <= 1'b1;
        pf_addr  <= fa;
        pf_data  <= flash_dout;
      end else if (bg_go || state_nx == S_ERR1) begin
        pf_valid <= 1'b0;
      end
    end
  end
`else
  localparam bit PF_EN = 1'b0;
  logic unused_pf;

  assign bg        = 1'b0;
  assign pend      = 1'b0;
  assign pend_err  = 1'b0;
  assign pend_a    = '0;
  assign pf_hit    = 1'b0;
  assign pf_data   = '0;
  assign unused_pf = ^{bg_go, pend_set, pf_fill};
`endif

  // state register
  always_ff @(posedge clk or negedge rst_i) begin
    if (!rst_i) state <= S_IDLE;
    else state <= state_nx;
  end

  // next state and datapath strobes
  always_comb begin
    state_nx = state;
    fa_ld    = 1'b0;
    fa_nx    = req_a;
    rd_ld    = 1'b0;
    rd_nx    = flash_dout;
    bg_go    = 1'b0;
    pend_set = 1'b0;
    pf_fill  = 1'b0;
    unique case (state)
      S_IDLE, S_DATA, S_ERR2: begin
        state_nx = S_IDLE;
        if (acc && bad) begin
          state_nx = S_ERR1;
        end else if (acc && pf_hit) begin
          state_nx = S_DATA;
          fa_ld    = 1'b1;
          rd_ld    = 1'b1;
          rd_nx    = pf_data;
        end else if (acc) begin
          state_nx = S_SETUP;
          fa_ld    = 1'b1;
        end else if (PF_EN && state == S_DATA && fa != A_TOP) begin
          state_nx = S_SETUP;
          fa_ld    = 1'b1;
          fa_nx    = fa + 1'b1;
          bg_go    = 1'b1;
        end
      end
      S_SETUP: begin
        state_nx = S_WAIT;
        pend_set = acc;
      end
      S_WAIT: begin
        if (!fin) begin
          pend_set = acc;
        end else if (!bg) begin
          state_nx = S_DATA;
          rd_ld    = 1'b1;
        end else if (r_go && r_bad) begin
          state_nx = S_ERR1;
        end else if (r_go && r_a == fa) begin
          state_nx = S_DATA;
          rd_ld    = 1'b1;
        end else if (r_go) begin
          state_nx = S_SETUP;
          fa_ld    = 1'b1;
          fa_nx    = r_a;
        end else begin
          state_nx = S_IDLE;
          pf_fill  = 1'b1;
        end
      end
      S_ERR1:  state_nx = S_ERR2;
      default: state_nx = S_IDLE;
    endcase
  end

  // bus and flash control outputs
  always_comb begin
    hreadyout = 1'b1;
    hresp     = 1'b0;
    flash_se  = 1'b0;
    unique case (state)
      S_SETUP: begin
        flash_se  = 1'b1;
        hreadyout = busy_ok;
      end
      S_WAIT: hreadyout = busy_ok;
      S_ERR1: begin
        hreadyout = 1'b0;
        hresp     = 1'b1;
      end
      S_ERR2:  hresp = 1'b1;
      default: ;
    endcase
  end

  // latency counter, flash address and read data registers
  always_ff @(posedge clk or negedge rst_i) begin
    if (!rst_i) begin
      cnt    <= '0;
      fa     <= '0;
      hrdata <= '0;
    end else begin
      if (state == S_SETUP) cnt <= LAT_M1;
      else if (state == S_WAIT && cnt != '0) cnt <= cnt - 1'b1;
      if (fa_ld) fa <= fa_nx;
      if (rd_ld) hrdata <= rd_nx;
    end
  end

endmodule

// File: tb/tb_emcu_flash_ahb_slave.sv
// tb_emcu_flash_ahb_slave: directed bench, two slaves (READ_LAT 1 and 3)
// on shared bus wires, each with its own flash latency model.
module tb_emcu_flash_ahb_slave;

  logic        clk = 1'b0;
  logic        rst_i;
  logic        hsel1, hsel3;
  logic [31:0] haddr;
  logic [1:0]  htrans;
  logic        hwrite;
  logic [2:0]  hsize;
  logic        rdy1, resp1, se1;
  logic        rdy3, resp3, se3;
  logic [31:0] rdata1, rdata3, dout1, dout3;
  logic [6:0]  x1, x3;
  logic [5:0]  y1, y3;

  int   n_cmp = 0;
  int   n_bad = 0;
  int   se_n1 = 0;
  int   se_n3 = 0;
  logic se_dbl = 1'b0;
  logic se1_q = 1'b0;
  logic se3_q = 1'b0;

  always #5 clk = ~clk;

  emcu_flash_ahb_slave #(.ADDR_W(13), .READ_LAT(1), .WIN_W(18)) u_dut1 (
    .clk(clk), .rst_i(rst_i), .hsel(hsel1), .haddr(haddr),
    .htrans(htrans), .hwrite(hwrite), .hsize(hsize),
    .hreadymux(rdy1), .hreadyout(rdy1), .hresp(resp1),
    .hrdata(rdata1), .flash_xadr(x1), .flash_yadr(y1),
    .flash_se(se1), .flash_dout(dout1)
  );

  emcu_flash_ahb_slave #(.ADDR_W(13), .READ_LAT(3), .WIN_W(18)) u_dut3 (
    .clk(clk), .rst_i(rst_i), .hsel(hsel3), .haddr(haddr),
    .htrans(htrans), .hwrite(hwrite), .hsize(hsize),
    .hreadymux(rdy3), .hreadyout(rdy3), .hresp(resp3),
    .hrdata(rdata3), .flash_xadr(x3), .flash_yadr(y3),
    .flash_se(se3), .flash_dout(dout3)
  );

  function automatic logic [31:0] word(input logic [12:0] a);
    return {16'hF1A5, 3'b000, a};
  endfunction

  // flash models: DOUT valid only in the cycle READ_LAT after the SE pulse
  logic        p1_v;
  logic [12:0] p1_a;
  logic [2:0]  p3_v;
  logic [12:0] p3_a [3];

  always @(posedge clk or negedge rst_i) begin
    if (!rst_i) begin
      p1_v <= 1'b0;
      p3_v <= '0;
    end else begin
      p1_v    <= se1;
      p1_a    <= {x1, y1};
      p3_v    <= {p3_v[1:0], se3};
      p3_a[2] <= p3_a[1];
      p3_a[1] <= p3_a[0];
      p3_a[0] <= {x3, y3};
    end
  end

  assign dout1 = p1_v ? word(p1_a) : 32'hDEAD_BEEF;
  assign dout3 = p3_v[2] ? word(p3_a[2]) : 32'hDEAD_BEEF;

  always @(posedge clk) begin
    if (se1) se_n1 <= se_n1 + 1;
    if (se3) se_n3 <= se_n3 + 1;
    if ((se1 && se1_q) || (se3 && se3_q)) se_dbl <= 1'b1;
    se1_q <= se1;
    se3_q <= se3;
  end

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic bus_idle;
    hsel1  = 1'b0;
    hsel3  = 1'b0;
    haddr  = '0;
    htrans = 2'b00;
    hwrite = 1'b0;
    hsize  = 3'd2;
  endtask

  task automatic addr_phase(input logic d3, input logic [31:0] a,
                            input logic wr, input logic [2:0] sz,
                            input logic [1:0] tr);
    hsel1  = !d3;
    hsel3  = d3;
    haddr  = a;
    hwrite = wr;
    hsize  = sz;
    htrans = tr;
  endtask

  task automatic do_reset;
    rst_i = 1'b0;
    tick;
    tick;
    rst_i = 1'b1;
    tick;
  endtask

  initial begin
    int c;
    int base;
    logic [31:0] adr [3];
    adr[0] = 32'h0;
    adr[1] = 32'h4;
    adr[2] = 32'h8;
    bus_idle();
    rst_i = 1'b1;
    #2 rst_i = 1'b0;
    tick;
    tick;
    rst_i = 1'b1;
    tick;
    check("rst_rdy", rdy1, 1);
    check("rst_resp", resp1, 0);
    check("rst_rdata", rdata1, 0);
    check("rst_se", se1, 0);
    check("rst_xy", {x1, y1}, 0);

    // full read of 0x10, then a second one cut by reset in WAIT
    addr_phase(1'b0, 32'h10, 1'b0, 3'd2, 2'b10);
    tick;
    bus_idle();
    tick;
    tick;
    check("pre_rdata", rdata1, word(13'd4));
    tick;
    addr_phase(1'b0, 32'h10, 1'b0, 3'd2, 2'b10);
    tick;
    bus_idle();
    tick;
    check("wait_rdy", rdy1, 0);
    rst_i = 1'b0;
    tick;
    check("mid_rst_se", se1, 0);
    check("mid_rst_rdy", rdy1, 1);
    check("mid_rst_rdata", rdata1, 0);
    rst_i = 1'b1;
    tick;

    // read 0x10 -> A=4, X=0 Y=4, ready at N+3
    addr_phase(1'b0, 32'h10, 1'b0, 3'd2, 2'b10);
    tick;
    bus_idle();
    check("t1_se", se1, 1);
    check("t1_x", x1, 0);
    check("t1_y", y1, 4);
    check("t1_setup_rdy", rdy1, 0);
    tick;
    check("t1_wait_rdy", rdy1, 0);
    check("t1_wait_se", se1, 0);
    tick;
    check("t1_data_rdy", rdy1, 1);
    check("t1_data", rdata1, word(13'd4));
    check("t1_resp", resp1, 0);
    tick;
    check("t1_hold", rdata1, word(13'd4));

    // write -> two-cycle error, no flash access
    do_reset();
    base = se_n1;
    addr_phase(1'b0, 32'h20, 1'b1, 3'd2, 2'b10);
    tick;
    bus_idle();
    check("wr_e1_rdy", rdy1, 0);
    check("wr_e1_resp", resp1, 1);
    tick;
    check("wr_e2_rdy", rdy1, 1);
    check("wr_e2_resp", resp1, 1);
    tick;
    check("wr_after_resp", resp1, 0);
    check("wr_no_se", 32'(se_n1 - base), 0);

    // oversize transfer -> error
    addr_phase(1'b0, 32'h0, 1'b0, 3'd3, 2'b10);
    tick;
    bus_idle();
    check("sz_e1_resp", resp1, 1);
    check("sz_e1_rdy", rdy1, 0);
    tick;
    tick;

    // out of window, then pipelined read of the top word
    do_reset();
    addr_phase(1'b0, 32'h0002_0000, 1'b0, 3'd2, 2'b10);
    tick;
    addr_phase(1'b0, 32'h0000_7FFC, 1'b0, 3'd2, 2'b10);
    check("oor_e1_resp", resp1, 1);
    check("oor_e1_rdy", rdy1, 0);
    check("oor_no_se", se1, 0);
    tick;
    check("oor_e2_rdy", rdy1, 1);
    check("oor_e2_resp", resp1, 1);
    tick;
    bus_idle();
    check("top_se", se1, 1);
    check("top_x", x1, 127);
    check("top_y", y1, 63);
    check("top_resp", resp1, 0);
    tick;
    tick;
    check("top_rdy", rdy1, 1);
    check("top_data", rdata1, word(13'd8191));
    tick;

    // READ_LAT=3 back-to-back reads of 0x0, 0x4, 0x8
    do_reset();
    base = se_n3;
    addr_phase(1'b1, adr[0], 1'b0, 3'd2, 2'b10);
    tick;
    for (int i = 0; i < 3; i++) begin
      check($sformatf("b2b%0d_se", i), se3, 1);
      check($sformatf("b2b%0d_a", i), {x3, y3}, adr[i] >> 2);
      if (i < 2) addr_phase(1'b1, adr[i+1], 1'b0, 3'd2, 2'b10);
      else bus_idle();
      c = 0;
      do begin
        tick;
        c++;
      end while (!rdy3 && c < 20);
      check($sformatf("b2b%0d_lat", i), c, 4);
      check($sformatf("b2b%0d_data", i), rdata3, word(13'(adr[i] >> 2)));
      tick;
    end
    check("b2b_se_cnt", 32'(se_n3 - base), 3);
    check("se_never_dbl", se_dbl, 0);

`ifdef EMCU_FLASH_PREFETCH_EN
    // 0x100 then SEQ 0x104 after an idle gap: served from the buffer
    do_reset();
    addr_phase(1'b0, 32'h100, 1'b0, 3'd2, 2'b10);
    tick;
    bus_idle();
    tick;
    tick;
    check("pf_d0", rdata1, word(13'h40));
    tick;
    check("pf_bg_se", se1, 1);
    check("pf_bg_a", {x1, y1}, 13'h41);
    check("pf_bg_rdy", rdy1, 1);
    tick;
    tick;
    tick;
    addr_phase(1'b0, 32'h104, 1'b0, 3'd2, 2'b11);
    tick;
    bus_idle();
    check("pf_hit_rdy", rdy1, 1);
    check("pf_hit_data", rdata1, word(13'h41));
    tick;
    check("pf_next_se", se1, 1);
    check("pf_next_a", {x1, y1}, 13'h42);
    tick;
    tick;
    tick;

    // top word: no prefetch afterwards
    addr_phase(1'b0, 32'h7FFC, 1'b0, 3'd2, 2'b10);
    tick;
    bus_idle();
    tick;
    tick;
    check("pf_top_data", rdata1, word(13'd8191));
    tick;
    check("pf_top_no_se", se1, 0);

    // other address during a prefetch: stall, then fresh read
    addr_phase(1'b0, 32'h100, 1'b0, 3'd2, 2'b10);
    tick;
    bus_idle();
    tick;
    tick;
    tick;
    check("pf_run_se", se1, 1);
    addr_phase(1'b0, 32'h200, 1'b0, 3'd2, 2'b10);
    tick;
    bus_idle();
    check("pf_stall", rdy1, 0);
    tick;
    check("pf_miss_se", se1, 1);
    check("pf_miss_a", {x1, y1}, 13'h80);
    tick;
    tick;
    check("pf_miss_rdy", rdy1, 1);
    check("pf_miss_data", rdata1, word(13'h80));
    tick;
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
